// File: rtl/spin_pkg.sv
// Shared types and helpers for the parametrised LED wheel.
// State encoding and the modulo position increment.
package spin_pkg;

    typedef enum logic [1:0] {
        ST_SPIN,
        ST_COAST,
        ST_STOPPED
    } state_e;

    function automatic int unsigned pos_inc(
        input int unsigned pos,
        input int unsigned n_pos
    );
        return (pos + 1 >= n_pos) ? 0 : pos + 1;
    endfunction

endpackage

// File: rtl/wheel_coast_ctr.sv
// Coast timing for the wheel: each step waits one tick longer than the last.
// Owns the gap length, the tick count inside a gap and the remaining steps.
module wheel_coast_ctr #(
    parameter int RAND_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic [RAND_W-1:0] rand_i,
    input  logic              tick_i,
    output logic              step_o,
    output logic              last_o
);

    localparam int GAP_W = RAND_W + 1;
    localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(1) << RAND_W;

    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
    logic [RAND_W-1:0] left_q, left_d;
    logic              step;

    // No steps remain once the count is exhausted, even on a tick.
    assign step = tick_i && (left_q != '0)
               && (gap_cnt_q + GAP_W'(1) == gap_q);

    always_comb begin
        gap_d     = gap_q;
        gap_cnt_d = gap_cnt_q;
        left_d    = left_q;
        if (load_i) begin
            left_d    = rand_i;
            gap_d     = GAP_W'(1);
            gap_cnt_d = '0;
        end else if (step) begin
            gap_cnt_d = '0;
            left_d    = left_q - RAND_W'(1);
            if (gap_q != GAP_MAX) begin
                gap_d = gap_q + GAP_W'(1);
            end
        end else if (tick_i && left_q != '0) begin
            gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            gap_q     <= GAP_W'(1);
            gap_cnt_q <= '0;
            left_q    <= '0;
        end else begin
            gap_q     <= gap_d;
            gap_cnt_q <= gap_cnt_d;
            left_q    <= left_d;
        end
    end

    assign step_o = step;
    assign last_o = (left_q == '0) || (step && left_q == RAND_W'(1));

endmodule

// File: rtl/spin_wheel_n.sv
// N-position spinning wheel with random coast-down, guess evaluation
// and a saturating hit score.
module spin_wheel_n
    import spin_pkg::*;
#(
    parameter  int N_POS   = 6,
    parameter  int RAND_W  = 4,
    parameter  int SCORE_W = 4,
    localparam int POS_W   = ($clog2(N_POS) > 1) ? $clog2(N_POS) : 1
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               tick_i,
    input  logic               stop_i,
    input  logic [RAND_W-1:0]  rand_i,
    input  logic [N_POS-1:0]   guess_i,
    output logic [POS_W-1:0]   pos_o,
    output logic               running_o,
    output logic               done_o,
    output logic               hit_o,
    output logic [SCORE_W-1:0] score_o
);

    state_e             state_q, state_d;
    logic [POS_W-1:0]   pos_q, pos_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic               stop_q;
    logic               running_q, running_d;
    logic               done_q, done_d;
    logic               hit_q, hit_d;
    logic               stop_rise;
    logic               load;
    logic               coast_tick;
    logic               step;
    logic               last;
    logic [POS_W-1:0]   pos_next;

    assign stop_rise  = stop_i & ~stop_q;
    assign coast_tick = tick_i & (state_q == ST_COAST);
    assign pos_next   = POS_W'(pos_inc(32'(pos_q), N_POS));

    wheel_coast_ctr #(
        .RAND_W (RAND_W)
    ) u_coast (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .load_i (load),
        .rand_i (rand_i),
        .tick_i (coast_tick),
        .step_o (step),
        .last_o (last)
    );

    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        score_d = score_q;
        hit_d   = hit_q;
        done_d  = 1'b0;
        load    = 1'b0;
        unique case (state_q)
            ST_SPIN: begin
                if (tick_i) pos_d = pos_next;
                if (stop_rise) begin
                    load    = 1'b1;
                    state_d = ST_COAST;
                end
            end
            ST_COAST: begin
                if (step) pos_d = pos_next;
                // Evaluate against the position the wheel lands on.
                if (last) begin
                    state_d = ST_STOPPED;
                    done_d  = 1'b1;
                    hit_d   = guess_i[pos_d];
                    if (guess_i[pos_d] && score_q != '1) begin
                        score_d = score_q + SCORE_W'(1);
                    end
                end
            end
            ST_STOPPED: begin
                if (stop_rise) state_d = ST_SPIN;
            end
            default: state_d = ST_SPIN;
        endcase
        running_d = (state_d != ST_STOPPED);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_SPIN;
            pos_q     <= '0;
            score_q   <= '0;
            stop_q    <= 1'b0;
            running_q <= 1'b1;
            done_q    <= 1'b0;
            hit_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pos_q     <= pos_d;
            score_q   <= score_d;
            stop_q    <= stop_i;
            running_q <= running_d;
            done_q    <= done_d;
            hit_q     <= hit_d;
        end
    end

    assign pos_o     = pos_q;
    assign running_o = running_q;
    assign done_o    = done_q;
    assign hit_o     = hit_q;
    assign score_o   = score_q;

endmodule

// File: tb/tb_spin_wheel_n.sv
// Randomised scoreboard bench for spin_wheel_n (N_POS=6, SCORE_W=2).
module tb_spin_wheel_n;

    localparam int N  = 6;
    localparam int RW = 4;
    localparam int SW = 2;
    localparam int PW = 3;
    localparam int SMAX = (1 << SW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          tick = 1'b0;
    logic          stop = 1'b0;
    logic [RW-1:0] rnd = '0;
    logic [N-1:0]  guess = '0;
    logic [PW-1:0] pos;
    logic          running;
    logic          done;
    logic          hit;
    logic [SW-1:0] score;

    spin_wheel_n #(
        .N_POS   (N),
        .RAND_W  (RW),
        .SCORE_W (SW)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .tick_i    (tick),
        .stop_i    (stop),
        .rand_i    (rnd),
        .guess_i   (guess),
        .pos_o     (pos),
        .running_o (running),
        .done_o    (done),
        .hit_o     (hit),
        .score_o   (score)
    );

    always #5 clk = ~clk;

    typedef struct {
        int pos;
        bit hit;
        int score;
    } exp_t;

    exp_t sbq[$];
    int   checks   = 0;
    int   errors   = 0;
    int   done_cnt = 0;
    int   m_pos    = 0;
    int   m_score  = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Number of coast steps completed after cnt ticks: step k needs k ticks.
    function automatic int steps_done(input int cnt);
        int k;
        k = 0;
        while ((k + 1) * (k + 2) / 2 <= cnt) k++;
        return k;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && done) begin
            done_cnt++;
            if (sbq.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e = sbq.pop_front();
                chk("halt_pos", int'(pos), e.pos);
                chk("halt_hit", int'(hit), int'(e.hit));
                chk("halt_score", int'(score), e.score);
                chk("halt_running", int'(running), 0);
            end
        end
    end

    task automatic step(input bit t, input bit s);
        tick = t;
        stop = s;
        @(posedge clk);
        #1;
    endtask

    task automatic spin(input int n, input bit rnd_ticks);
        bit t;
        for (int i = 0; i < n; i++) begin
            t = rnd_ticks ? bit'($urandom % 2) : 1'b1;
            step(t, 1'b0);
            if (t) m_pos = (m_pos + 1) % N;
            chk("spin_pos", int'(pos), m_pos);
            chk("spin_running", int'(running), 1);
        end
    endtask

    task automatic round(input int pre, input bit rnd_pre, input bit coincide,
                         input int r, input logic [N-1:0] g, input bit noise);
        int start, fin, total, cnt, guard, d0;
        bit h, t, s;
        spin(pre, rnd_pre);
        guess = g;
        rnd   = RW'(r);
        start = coincide ? (m_pos + 1) % N : m_pos;
        fin   = (start + r) % N;
        h     = g[fin];
        if (h && m_score < SMAX) m_score++;
        sbq.push_back('{fin, h, m_score});
        d0 = done_cnt;
        step(coincide, 1'b1);
        chk("capture_pos", int'(pos), start);
        chk("capture_running", int'(running), 1);
        rnd   = RW'($urandom);
        total = r * (r + 1) / 2;
        cnt   = 0;
        guard = 0;
        if (r == 0) begin
            step(1'b1, 1'b0);
            chk("zero_coast_pos", int'(pos), start);
        end else begin
            while (cnt < total && guard < 2000) begin
                t = bit'($urandom % 2);
                s = noise && ($urandom % 4 == 0);
                step(t, s);
                guard++;
                if (t) cnt++;
                chk("coast_pos", int'(pos), (start + steps_done(cnt)) % N);
                if (cnt < total) chk("coast_running", int'(running), 1);
            end
            if (cnt < total) chk("coast_timeout", cnt, total);
        end
        stop = 1'b0;
        tick = 1'b0;
        @(negedge clk);
        #1;
        chk("done_count", done_cnt - d0, 1);
        chk("stopped_running", int'(running), 0);
        m_pos = fin;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0);
            chk("stopped_pos", int'(pos), fin);
            chk("stopped_hit", int'(hit), int'(h));
            chk("stopped_score", int'(score), m_score);
            chk("stopped_done", int'(done), 0);
        end
        chk("done_once", done_cnt - d0, 1);
        guess = N'($urandom);
        step(1'b0, 1'b1);
        chk("restart_running", int'(running), 1);
        chk("restart_hit_hold", int'(hit), int'(h));
        step(1'b0, 1'b0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pos", int'(pos), 0);
        chk("rst_running", int'(running), 1);
        chk("rst_done", int'(done), 0);
        chk("rst_hit", int'(hit), 0);
        chk("rst_score", int'(score), 0);
        rst_n = 1'b1;
        spin(7, 1'b0);
        spin(1, 1'b0);
        round(0, 1'b0, 1'b0, 3, 6'b100000, 1'b0);
        round(0, 1'b0, 1'b0, 0, 6'b111111, 1'b0);
        round(0, 1'b0, 1'b1, 2, N'($urandom), 1'b1);
        for (int i = 0; i < 20; i++) begin
            round(int'($urandom % 8), 1'b1, bit'($urandom % 2),
                  int'($urandom % (1 << RW)), N'($urandom), 1'b1);
        end
        // Abort a coast with an asynchronous reset between clock edges.
        spin(3, 1'b1);
        rnd = RW'(10);
        step(1'b0, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("amid_rst_pos", int'(pos), 0);
        chk("amid_rst_running", int'(running), 1);
        chk("amid_rst_done", int'(done), 0);
        chk("amid_rst_hit", int'(hit), 0);
        chk("amid_rst_score", int'(score), 0);
        sbq.delete();
        tick = 1'b0;
        stop = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n   = 1'b1;
        m_pos   = 0;
        m_score = 0;
        step(1'b0, 1'b0);
        chk("post_rst_pos", int'(pos), 0);
        spin(5, 1'b0);
        for (int i = 0; i < 5; i++) begin
            round(int'($urandom % 4), 1'b1, 1'b0,
                  int'($urandom % 6), '1, 1'b0);
        end
        chk("final_score_sat", int'(score), SMAX);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spin_wheel_n.md
# spin_wheel_n

Parametrised successor to the six-position LED wheel. It steps a wheel of `N_POS` positions on prescaler ticks. A stop request makes the wheel coast to a halt over a random number of steps, with a growing gap between steps. At halt it evaluates a per-position guess mask and keeps a saturating hit score. It sits between the prescaler/LFSR and the segment/LED drivers.

## Interface
Parameters:
- `N_POS`, default 6: number of wheel positions, legal range 2..16.
- `RAND_W`, default 4: width of the random input. Maximum coast length is 2^`RAND_W`−1 steps.
- `SCORE_W`, default 4: width of the hit score counter.
- `POS_W` (localparam) = max(1, $clog2(`N_POS`)).

Ports:
- `clk_i`  in  1: the single clock.
- `rst_ni`  in  1: asynchronous, active-low reset.
- `tick_i`  in  1: one-cycle step strobe from the prescaler.
- `stop_i`  in  1: stop/restart button, level. Synchronised upstream.
- `rand_i`  in  `RAND_W`: LFSR value. Sampled on stop capture.
- `guess_i`  in  `N_POS`: guess mask. Bit k set means "guess position k".
- `pos_o`  out  `POS_W`: current position, 0..`N_POS`−1.
- `running_o`  out  1: high in SPIN and COAST.
- `done_o`  out  1: one-cycle pulse on entry to STOPPED.
- `hit_o`  out  1: result of the last evaluation. Held until the next round.
- `score_o`  out  `SCORE_W`: accumulated hits, saturating.

## Operation
- States: SPIN, COAST, STOPPED.
- Reset values: state=SPIN, `pos_o`=0, `running_o`=1, `done_o`=0, `hit_o`=0, `score_o`=0, `stop_q`=0.
- Stop edge detection: `stop_q` registers `stop_i`. `stop_rise` = `stop_i` & ~`stop_q`. Only rising edges act; a held level does nothing further.
- SPIN:
  - Each `tick_i` advances `pos_o` by 1, wrapping from `N_POS`−1 to 0.
  - On `stop_rise`, capture `coast_left` = `rand_i`, set `gap` = 1 and `gap_cnt` = 0, then enter COAST.
  - If `tick_i` and `stop_rise` coincide, the step still happens in that same cycle.
- COAST:
  - Each `tick_i` increments `gap_cnt`.
  - When `gap_cnt`+1 == `gap`:
    - `pos_o` steps (with wrap) and `gap_cnt` clears.
    - `gap` increments, saturating at 2^`RAND_W`.
    - `coast_left` decrements.
  - When `coast_left` reaches 0, enter STOPPED on that same edge.
  - If `coast_left` was captured as 0, go to STOPPED on the next clock with no step.
  - `stop_rise` is ignored in COAST.
- STOPPED entry:
  - `hit_o` = `guess_i`[new `pos_o`], where new `pos_o` is the post-step value.
  - `score_o` increments when hit, saturating at 2^`SCORE_W`−1.
  - `done_o` = 1 for exactly one cycle.
  - `running_o` = 0.
- STOPPED:
  - `pos_o`, `hit_o` and `score_o` hold.
  - `tick_i` is ignored.
  - `stop_rise` returns to SPIN. `hit_o` stays until the next evaluation.
- Only reset clears `score_o`.
- `guess_i` bits at or above `N_POS` do not exist. The mask is exactly `N_POS` wide.

## Timing
- All outputs are registered.
- `stop_i` rising at edge n makes `stop_rise` true during cycle n. `running_o` stays 1 in COAST; the state change becomes visible after edge n+1.
- Coast step k (k = 1..`coast_left`) occurs on the k-th qualifying tick, i.e. after gap=k ticks.
- Total ticks from capture to halt = `coast_left`·(`coast_left`+1)/2. Example: `rand_i`=3 gives 1+2+3 = 6 ticks.
- `done_o`, `hit_o` and `score_o` update on the same edge as the final `pos_o` step.
- Reset mid-coast: all state returns to the reset values asynchronously. The first step after release needs a fresh `tick_i`.

## Structure
- Package `spin_pkg` holds:
  - the state enum (`ST_SPIN`, `ST_COAST`, `ST_STOPPED`);
  - a `pos_inc` function (modulo-`N_POS` increment).
- Sub-module `wheel_coast_ctr` owns `gap`, `gap_cnt` and `coast_left`:
  - inputs: `load`, `rand`, `tick`;
  - outputs: `step`, `last`.
- The top FSM owns `pos`, the stop edge detector, evaluation and score.

## Test plan
- Reset then 7 ticks in SPIN with `N_POS`=6: `pos_o` reads 1,2,3,4,5,0,1; `running_o`=1 throughout.
- `stop_i` rises at `pos_o`=2, `rand_i`=3, `guess_i`=6'b100000: steps occur after ticks 1, 3 and 6 of coast. Halt at `pos_o`=5 with `done_o` pulsed once, `hit_o`=1, `score_o`=1.
- `rand_i`=0 at stop: STOPPED on the next clock, `pos_o` unchanged, `done_o` pulses once. `hit_o` reflects the current position.
- `tick_i` and `stop_rise` in the same cycle at `pos_o`=5: `pos_o`→0 and COAST is entered. A second `stop_i` pulse during COAST has no effect.
- `SCORE_W`=2, five consecutive winning rounds (restart via `stop_i`): `score_o` goes 1,2,3,3,3.
- `rst_ni` asserted mid-COAST: outputs go to the reset values immediately. After release the wheel spins from 0 and `score_o`=0.
